// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory access controller: FSM states,
// WB-stage load control codes and store funct3 codes, plus the misalignment predicate.
package dmem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        DMACC_IDLE = 2'd0,
        DMACC_REQ  = 2'd1,
        DMACC_RESP = 2'd2
    } dmacc_state_e;

    // Load control codes follow the RISC-V load funct3 encoding.
    localparam logic [2:0] DMEM_LB  = 3'b000;
    localparam logic [2:0] DMEM_LH  = 3'b001;
    localparam logic [2:0] DMEM_LW  = 3'b010;
    localparam logic [2:0] DMEM_LBU = 3'b100;
    localparam logic [2:0] DMEM_LHU = 3'b101;

    localparam logic [2:0] FNC_SB = 3'b000;
    localparam logic [2:0] FNC_SH = 3'b001;
    localparam logic [2:0] FNC_SW = 3'b010;

    // Halfword needs an even offset, word needs offset 0; byte accesses never trap.
    function automatic logic dmacc_misaligned(
        input logic       is_store,
        input logic [2:0] funct3,
        input logic [2:0] control_load,
        input logic [1:0] offset
    );
        logic is_half;
        logic is_word;
        if (is_store) begin
            is_half = (funct3 == FNC_SH);
            is_word = (funct3 == FNC_SW);
        end else begin
            is_half = (control_load == DMEM_LH) || (control_load == DMEM_LHU);
            is_word = (control_load == DMEM_LW);
        end
        return (is_half && offset[0]) || (is_word && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_store_align.sv
// Store lane alignment: places rs2 data on the byte lanes selected by the address
// offset and store size. Counterpart of the WB-stage load extractor.
module dmem_access_ctrl_store_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic [1:0]  addr_offset_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  we_o,
    output logic [31:0] wdata_o
);

    always_comb begin
        we_o    = 4'b0000;
        wdata_o = wdata_i;
        case (funct3_i)
            FNC_SB: begin
                we_o    = 4'b0001 << addr_offset_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            FNC_SH: begin
                // Only offset bit 1 selects the half; bit 0 is dropped here.
                we_o    = 4'b0011 << {addr_offset_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            FNC_SW: begin
                we_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                we_o    = 4'b0000;
                wdata_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: one outstanding handshaked load/store,
// pipeline stall until done, registered raw read word for WB. Optional misaligned-access
// trap is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  op_valid,
    input  logic                  op_is_load,
    input  logic                  op_is_store,
    input  logic [2:0]            op_control_load,
    input  logic [2:0]            op_funct3,
    input  logic [ADDR_WIDTH-1:0] op_addr,
    input  logic [31:0]           op_wdata,
    output logic                  stall,

    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [3:0]            req_we,
    output logic [31:0]           req_wdata,
    input  logic                  resp_valid,
    input  logic [31:0]           resp_rdata,

    output logic                  wb_valid,
    output logic [1:0]            wb_addr_offset,
    output logic [2:0]            wb_control_load,
    output logic [31:0]           wb_rdata,
    output logic                  misalign_err
);

    dmacc_state_e          state_q, state_d;
    logic                  req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            we_q, we_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  is_load_q, is_load_d;
    logic [1:0]            offset_q, offset_d;
    logic [2:0]            ctrl_q, ctrl_d;

    logic                  wb_valid_q, wb_valid_d;
    logic [31:0]           wb_rdata_q, wb_rdata_d;
    logic [1:0]            wb_offset_q, wb_offset_d;
    logic [2:0]            wb_ctrl_q, wb_ctrl_d;

    logic                  op_req;
    logic                  misalign;
    logic                  stall_c;
    logic [3:0]            align_we;
    logic [31:0]           align_wdata;

    dmem_access_ctrl_store_align u_store_align (
        .addr_offset_i (op_addr[1:0]),
        .funct3_i      (op_funct3),
        .wdata_i       (op_wdata),
        .we_o          (align_we),
        .wdata_o       (align_wdata)
    );

    assign op_req = op_valid && (op_is_load || op_is_store);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = op_req && (state_q == DMACC_IDLE) &&
                      dmacc_misaligned(op_is_store, op_funct3, op_control_load, op_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        is_load_d   = is_load_q;
        offset_d    = offset_q;
        ctrl_d      = ctrl_q;
        wb_valid_d  = 1'b0;
        wb_rdata_d  = wb_rdata_q;
        wb_offset_d = wb_offset_q;
        wb_ctrl_d   = wb_ctrl_q;
        stall_c     = 1'b0;

        unique case (state_q)
            DMACC_IDLE: begin
                if (op_req && !misalign) begin
                    state_d   = DMACC_REQ;
                    addr_d    = {op_addr[ADDR_WIDTH-1:2], 2'b00};
                    // Store wins when both flags are set.
                    is_load_d = !op_is_store;
                    we_d      = op_is_store ? align_we : 4'b0000;
                    wdata_d   = op_is_store ? align_wdata : 32'h0;
                    offset_d  = op_addr[1:0];
                    ctrl_d    = op_control_load;
                    stall_c   = 1'b1;
                end
            end
            DMACC_REQ: begin
                stall_c = 1'b1;
                if (req_ready) begin
                    if (is_load_q) begin
                        state_d = DMACC_RESP;
                    end else begin
                        state_d = DMACC_IDLE;
                        stall_c = 1'b0;
                    end
                end
            end
            DMACC_RESP: begin
                stall_c = 1'b1;
                if (resp_valid) begin
                    state_d     = DMACC_IDLE;
                    stall_c     = 1'b0;
                    wb_valid_d  = 1'b1;
                    wb_rdata_d  = resp_rdata;
                    wb_offset_d = offset_q;
                    wb_ctrl_d   = ctrl_q;
                end
            end
            default: begin
                state_d = DMACC_IDLE;
            end
        endcase

        req_valid_d = (state_d == DMACC_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DMACC_IDLE;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            we_q        <= 4'b0000;
            wdata_q     <= 32'h0;
            is_load_q   <= 1'b0;
            offset_q    <= 2'b00;
            ctrl_q      <= 3'b000;
            wb_valid_q  <= 1'b0;
            wb_rdata_q  <= 32'h0;
            wb_offset_q <= 2'b00;
            wb_ctrl_q   <= 3'b000;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            is_load_q   <= is_load_d;
            offset_q    <= offset_d;
            ctrl_q      <= ctrl_d;
            wb_valid_q  <= wb_valid_d;
            wb_rdata_q  <= wb_rdata_d;
            wb_offset_q <= wb_offset_d;
            wb_ctrl_q   <= wb_ctrl_d;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign stall           = stall_c && !rst;
    assign misalign_err    = misalign && !rst;
    assign req_valid       = req_valid_q;
    assign req_addr        = addr_q;
    assign req_we          = we_q;
    assign req_wdata       = wdata_q;
    assign wb_valid        = wb_valid_q;
    assign wb_rdata        = wb_rdata_q;
    assign wb_addr_offset  = wb_offset_q;
    assign wb_control_load = wb_ctrl_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with request/writeback scoreboards and a
// simple memory responder (configurable ready delay and response latency).
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_is_load, op_is_store;
    logic [2:0]  op_control_load, op_funct3;
    logic [31:0] op_addr, op_wdata;
    logic        stall;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_we;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        wb_valid;
    logic [1:0]  wb_addr_offset;
    logic [2:0]  wb_control_load;
    logic [31:0] wb_rdata;
    logic        misalign_err;

    dmem_access_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .op_valid        (op_valid),
        .op_is_load      (op_is_load),
        .op_is_store     (op_is_store),
        .op_control_load (op_control_load),
        .op_funct3       (op_funct3),
        .op_addr         (op_addr),
        .op_wdata        (op_wdata),
        .stall           (stall),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_we          (req_we),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .wb_valid        (wb_valid),
        .wb_addr_offset  (wb_addr_offset),
        .wb_control_load (wb_control_load),
        .wb_rdata        (wb_rdata),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        is_load;
        int          resp_delay;
        logic [31:0] rdata;
    } req_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  offset;
        logic [2:0]  ctrl;
    } wb_exp_t;

    req_exp_t    req_q[$];
    wb_exp_t     wb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          n_req = 0;
    int          n_wb = 0;
    int          n_mis = 0;
    int          stall_cnt = 0;
    int          ready_delay = 0;
    logic        ready_idle = 1'b0;
    int          resp_cnt = 0;
    logic [31:0] resp_data = 32'h0;
    logic        wb_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: handshakes and writeback pulses are scored at the falling edge.
    always @(negedge clk) begin
        req_exp_t e;
        wb_exp_t  w;
        if (!rst && stall) stall_cnt++;
        if (!rst && misalign_err) n_mis++;
        if (!rst && req_valid && req_ready) begin
            n_req++;
            chk("req_expected", req_q.size() != 0, 1);
            if (req_q.size() != 0) begin
                e = req_q.pop_front();
                chk("req_addr", req_addr, e.addr);
                chk("req_we", req_we, e.we);
                if (!e.is_load && e.we != 4'b0000) chk("req_wdata", req_wdata, e.wdata);
                if (e.is_load) begin
                    resp_cnt  = e.resp_delay;
                    resp_data = e.rdata;
                end
            end
        end
        if (wb_valid) begin
            n_wb++;
            chk("wb_single_pulse", wb_prev, 0);
            chk("wb_expected", wb_q.size() != 0, 1);
            if (wb_q.size() != 0) begin
                w = wb_q.pop_front();
                chk("wb_rdata", wb_rdata, w.rdata);
                chk("wb_addr_offset", wb_addr_offset, w.offset);
                chk("wb_control_load", wb_control_load, w.ctrl);
            end
        end
        wb_prev = wb_valid;
    end

    // Memory responder.
    initial begin
        int wait_cnt;
        wait_cnt   = 0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            resp_valid = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    resp_valid = 1'b1;
                    resp_rdata = resp_data;
                end
            end
            if (req_valid) begin
                req_ready = (wait_cnt >= ready_delay);
                wait_cnt++;
            end else begin
                req_ready = ready_idle;
                wait_cnt  = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] exp_we, input logic [31:0] exp_wd);
        req_q.push_back('{a & 32'hFFFF_FFFC, exp_we, exp_wd, 1'b0, 0, 32'h0});
        stall_cnt       = 0;
        op_valid        = 1'b1;
        op_is_store     = 1'b1;
        op_is_load      = 1'b0;
        op_funct3       = f3;
        op_control_load = DMEM_LW;
        op_addr         = a;
        op_wdata        = d;
    endtask

    task automatic drive_load(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] rd,
                              input int dly, input logic expect_wb);
        req_q.push_back('{a & 32'hFFFF_FFFC, 4'b0000, 32'h0, 1'b1, dly, rd});
        if (expect_wb) wb_q.push_back('{rd, a[1:0], ctrl});
        stall_cnt       = 0;
        op_valid        = 1'b1;
        op_is_store     = 1'b0;
        op_is_load      = 1'b1;
        op_funct3       = FNC_SW;
        op_control_load = ctrl;
        op_addr         = a;
        op_wdata        = 32'hFFFF_FFFF;
    endtask

    // Wait for the done cycle, then return just after the done edge.
    task automatic finish_op(input int max_cycles);
        int i;
        i = 0;
        #1;
        while (stall && i < max_cycles) begin
            @(posedge clk);
            #2;
            i++;
        end
        chk("op_done_in_time", stall, 0);
        step();
    endtask

    initial begin
        logic [3:0] sb_we [4];
        int         req_before;
        int         wb_before;
        sb_we[0] = 4'b0001;
        sb_we[1] = 4'b0010;
        sb_we[2] = 4'b0100;
        sb_we[3] = 4'b1000;

        rst = 1'b1;
        op_valid = 1'b0;
        op_is_load = 1'b0;
        op_is_store = 1'b0;
        op_control_load = 3'b000;
        op_funct3 = 3'b000;
        op_addr = 32'h0;
        op_wdata = 32'h0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_req_we", req_we, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rdata", wb_rdata, 0);
        chk("rst_misalign", misalign_err, 0);
        step();

        // SB with req_ready already high.
        ready_idle = 1'b1;
        drive_store(FNC_SB, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
        finish_op(20);
        op_valid = 1'b0;
        chk("sb_stall_cycles", stall_cnt, 1);
        chk("sb_req_count", n_req, 1);
        ready_idle = 1'b0;

        // SB on each lane, back to back.
        for (int o = 0; o < 4; o++) begin
            drive_store(FNC_SB, 32'h0000_1100 + o, 32'h1234_563C, sb_we[o], 32'h3C3C_3C3C);
            finish_op(20);
        end
        op_valid = 1'b0;

        // SH with req_ready low for 3 REQ cycles.
        ready_delay = 3;
        drive_store(FNC_SH, 32'h0000_2002, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);
        finish_op(20);
        op_valid = 1'b0;
        chk("sh_stall_cycles", stall_cnt, 4);
        ready_delay = 0;

        drive_store(FNC_SH, 32'h0000_2000, 32'h0000_7777, 4'b0011, 32'h7777_7777);
        finish_op(20);
        drive_store(FNC_SW, 32'h0000_5000, 32'h1122_3344, 4'b1111, 32'h1122_3344);
        finish_op(20);
        drive_store(3'b111, 32'h0000_5004, 32'h9999_9999, 4'b0000, 32'h0);
        finish_op(20);
        op_valid = 1'b0;
        step();

        // LBU with response in the second RESP cycle.
        drive_load(DMEM_LBU, 32'h0000_3001, 32'hDEAD_BEEF, 2, 1'b1);
        finish_op(20);
        op_valid = 1'b0;
        chk("lbu_wb_valid_after_done", wb_valid, 1);
        chk("lbu_stall_cycles", stall_cnt, 3);
        step();
        chk("lbu_wb_pulse_end", wb_valid, 0);

        // WB fields hold across a following store.
        drive_store(FNC_SW, 32'h0000_5008, 32'hABCD_0123, 4'b1111, 32'hABCD_0123);
        finish_op(20);
        op_valid = 1'b0;
        chk("wb_hold_rdata", wb_rdata, 32'hDEAD_BEEF);
        chk("wb_hold_offset", wb_addr_offset, 2'b01);
        chk("wb_hold_ctrl", wb_control_load, DMEM_LBU);
        step();

        // LW then SW with no bubble.
        req_before = n_req;
        drive_load(DMEM_LW, 32'h0000_7000, 32'hCAFE_F00D, 1, 1'b1);
        finish_op(20);
        chk("lw_stall_cycles", stall_cnt, 2);
        chk("lw_wb_valid_after_done", wb_valid, 1);
        drive_store(FNC_SW, 32'h0000_7004, 32'h55AA_55AA, 4'b1111, 32'h55AA_55AA);
        finish_op(20);
        op_valid = 1'b0;
        chk("sw_stall_cycles", stall_cnt, 1);
        repeat (2) step();
        chk("b2b_req_count", n_req - req_before, 2);

        // LH with 1-cycle response.
        drive_load(DMEM_LH, 32'h0000_6002, 32'h8765_4321, 1, 1'b1);
        finish_op(20);
        op_valid = 1'b0;
        repeat (2) step();

        // Reset while waiting in RESP; the late response must be ignored.
        wb_before = n_wb;
        drive_load(DMEM_LW, 32'h0000_8000, 32'h1234_5678, 4, 1'b0);
        step();
        step();
        rst = 1'b1;
        op_valid = 1'b0;
        step();
        #1;
        chk("rst_resp_req_valid", req_valid, 0);
        chk("rst_resp_stall", stall, 0);
        rst = 1'b0;
        repeat (6) step();
        chk("rst_resp_no_wb", n_wb - wb_before, 0);
        chk("rst_resp_stall_after", stall, 0);

        // Misaligned accesses.
        req_before = n_req;
`ifdef DMEM_MISALIGN_TRAP_EN
        op_valid = 1'b1;
        op_is_load = 1'b1;
        op_is_store = 1'b0;
        op_control_load = DMEM_LW;
        op_addr = 32'h0000_4002;
        #1;
        chk("mis_lw_err", misalign_err, 1);
        chk("mis_lw_stall", stall, 0);
        step();
        op_valid = 1'b0;
        #1;
        chk("mis_lw_err_end", misalign_err, 0);
        repeat (3) step();
        chk("mis_lw_no_req", n_req - req_before, 0);
        chk("mis_pulse_count", n_mis, 1);
`else
        drive_load(DMEM_LW, 32'h0000_4002, 32'h0BAD_F00D, 1, 1'b1);
        finish_op(20);
        op_valid = 1'b0;
        drive_store(FNC_SH, 32'h0000_2001, 32'h0000_4242, 4'b0011, 32'h4242_4242);
        finish_op(20);
        op_valid = 1'b0;
        repeat (3) step();
        chk("trunc_req_count", n_req - req_before, 2);
        chk("no_misalign_pulse", n_mis, 0);
`endif

        repeat (3) step();
        chk("req_scoreboard_empty", req_q.size(), 0);
        chk("wb_scoreboard_empty", wb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
